// File: rtl/ram_out_capture.sv
// Read-data capture FIFO for the RAM test environment, drained via valid/ready.
// Optional per-entry timestamps are built when RAM_CAP_TS_EN is defined.
module ram_out_capture #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        q_in,
  input  logic                     q_vld,
  output logic [DATA_W-1:0]        out_data,
  output logic [TS_W-1:0]          out_ts,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  output logic [7:0]               drop_cnt,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic          full_q,     full_d;
  logic          empty_q,    empty_d;
  logic          ovf_q,      ovf_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic push;
  logic pop;
  logic drop;

  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  always_comb begin
    pop  = !empty_q && out_rdy;
    push = q_vld && (!full_q || pop);
    drop = q_vld && full_q && !pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // A drop coinciding with clr_ovf restarts the tally at one.
  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (clr_ovf) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is not reset; the head is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      data_mem_q[wr_ptr_q] <= q_in;
    end
  end

`ifdef RAM_CAP_TS_EN
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] ts_mem_q [DEPTH];

  always_comb begin
    ts_d = ts_q + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  // Entries carry the counter value that becomes current at their push edge.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      ts_mem_q[wr_ptr_q] <= ts_d;
    end
  end

  always_comb begin
    out_ts = empty_q ? '0 : ts_mem_q[rd_ptr_q];
  end
`else
  always_comb begin
    out_ts = '0;
  end
`endif

  always_comb begin
    out_data = empty_q ? '0 : data_mem_q[rd_ptr_q];
    out_vld  = !empty_q;
    count    = count_q;
    full     = full_q;
    empty    = empty_q;
    ovf      = ovf_q;
    drop_cnt = drop_cnt_q;
  end

endmodule

// File: tb/tb_ram_out_capture.sv
// Bench for ram_out_capture: directed and random steps against a queue-based model.
module tb_ram_out_capture;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 8;
  localparam int TS_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] q_in;
  logic              q_vld;
  logic [DATA_W-1:0] out_data;
  logic [TS_W-1:0]   out_ts;
  logic              out_vld;
  logic              out_rdy;
  logic [3:0]        count;
  logic              full;
  logic              empty;
  logic              ovf;
  logic [7:0]        drop_cnt;
  logic              clr_ovf;

  ram_out_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .q_vld(q_vld),
    .out_data(out_data), .out_ts(out_ts), .out_vld(out_vld), .out_rdy(out_rdy),
    .count(count), .full(full), .empty(empty), .ovf(ovf),
    .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: queue of {timestamp, data}, sticky flag, drop tally, cycle counter.
  logic [7:0] mq[$];
  logic       m_ovf;
  int         m_drop;
  logic [3:0] m_ts;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_all();
    int sz;
    sz = mq.size();
    chk("out_vld", int'(out_vld), int'(sz != 0));
    chk("count", int'(count), sz);
    chk("full", int'(full), int'(sz == DEPTH));
    chk("empty", int'(empty), int'(sz == 0));
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("drop_cnt", int'(drop_cnt), m_drop);
    chk("out_data", int'(out_data), (sz != 0) ? int'(mq[0][3:0]) : 0);
`ifdef RAM_CAP_TS_EN
    chk("out_ts", int'(out_ts), (sz != 0) ? int'(mq[0][7:4]) : 0);
`else
    chk("out_ts", int'(out_ts), 0);
`endif
  endtask

  task automatic step(input logic v, input logic [3:0] d, input logic r,
                      input logic c, input logic rs);
    bit do_pop, do_push;
    @(negedge clk);
    q_vld = v; q_in = d; out_rdy = r; clr_ovf = c; rst = rs;
    @(posedge clk);
    if (rs) begin
      mq.delete(); m_ovf = 1'b0; m_drop = 0; m_ts = '0;
    end else begin
      m_ts    = m_ts + 4'd1;
      do_pop  = (mq.size() != 0) && r;
      do_push = v && ((mq.size() < DEPTH) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({m_ts, d});
      if (v && !do_push) begin
        m_ovf  = 1'b1;
        m_drop = c ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
      end else if (c) begin
        m_ovf = 1'b0; m_drop = 0;
      end
    end
    #1 check_all();
  endtask

  initial begin
    rst = 1'b1; q_vld = 1'b0; q_in = '0; out_rdy = 1'b0; clr_ovf = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_drop = 0; m_ts = '0;

    // Reset state, then a single push becomes visible after one edge.
    step(0, 0, 0, 0, 1);
    step(1, 4'h3, 0, 0, 0);
    chk("first_data", int'(out_data), 3);
    chk("first_count", int'(count), 1);
`ifdef RAM_CAP_TS_EN
    chk("first_ts", int'(out_ts), 1);
`endif
    step(0, 0, 1, 0, 0);

    // Fill 0..7, drain in order.
    for (int i = 0; i < 8; i++) step(1, 4'(i), 0, 0, 0);
    chk("fill_full", int'(full), 1);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", int'(out_data), i);
      step(0, 0, 1, 0, 0);
    end
    chk("drain_empty", int'(empty), 1);

    // Overflow: three drops, then clr_ovf colliding with a drop.
    for (int i = 0; i < 8; i++) step(1, 4'(i + 8), 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 4'h5, 0, 0, 0);
    chk("drop3", int'(drop_cnt), 3);
    step(1, 4'h6, 0, 1, 0);
    chk("clr_vs_drop", int'(drop_cnt), 1);
    step(0, 0, 0, 1, 0);
    chk("clr_done", int'(ovf), 0);

    // Full with simultaneous push and pop across pointer wrap.
    for (int i = 0; i < 20; i++) step(1, 4'(i), 1, 0, 0);
    chk("stream_count", int'(count), 8);

    // Reset with 5 entries stored, then 0xA is the new head.
    step(0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 4'(i), 0, 0, 0);
    step(1, 4'h9, 0, 0, 1);
    step(1, 4'hA, 0, 0, 0);
    chk("post_rst_head", int'(out_data), 10);

    // 300 drop attempts saturate the tally.
    for (int i = 0; i < 7; i++) step(1, 4'(i), 0, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 4'($urandom), 0, 0, 0);
    chk("drop_sat", int'(drop_cnt), 255);

    // Timestamp wrap: pushes land on counter values 14, 15, 0, 1.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 13; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 4'(i), 0, 0, 0);
`ifdef RAM_CAP_TS_EN
    chk("ts_wrap0", int'(out_ts), 14);
    step(0, 0, 1, 0, 0);
    chk("ts_wrap1", int'(out_ts), 15);
    step(0, 0, 1, 0, 0);
    chk("ts_wrap2", int'(out_ts), 0);
    step(0, 0, 1, 0, 0);
    chk("ts_wrap3", int'(out_ts), 1);
`endif

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
